// File: rtl/id_stage_decoder_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation classes, immediate formats
// and the ID/EX pipeline bundle consumed by the execute stage.
package id_stage_decoder_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ALU_LDST   = 3'd0,
        ALU_BRANCH = 3'd1,
        ALU_R      = 3'd2,
        ALU_I      = 3'd3,
        ALU_LUI    = 3'd4,
        ALU_AUIPC  = 3'd5,
        ALU_JAL    = 3'd6,
        ALU_JALR   = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_R     = 3'd1,
        FMT_I     = 3'd2,
        FMT_SHAMT = 3'd3,
        FMT_S     = 3'd4,
        FMT_B     = 3'd5,
        FMT_U     = 3'd6,
        FMT_J     = 3'd7
    } imm_fmt_e;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       npc;
        alu_op_e               alu_op;
        logic [2:0]            func3;
        logic                  func7;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
    } id_state_t;

    // Which register sources an encoding format actually reads (for hazard detection).
    function automatic logic fmt_uses_rs1(input imm_fmt_e fmt);
        return fmt inside {FMT_R, FMT_I, FMT_SHAMT, FMT_S, FMT_B};
    endfunction

    function automatic logic fmt_uses_rs2(input imm_fmt_e fmt);
        return fmt inside {FMT_R, FMT_S, FMT_B};
    endfunction

endpackage

// File: rtl/id_stage_decoder_imm_gen.sv
// Immediate generator: classifies the instruction format and builds the
// sign-extended immediate (branch/jump offsets kept in halfword units).
module id_stage_decoder_imm_gen
    import id_stage_decoder_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        case (instr[6:0])
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP_IMM: begin
                // func3 001/101 are the shift-immediate forms
                if (instr[13:12] == 2'b01) begin
                    fmt = FMT_SHAMT;
                    imm = {27'b0, instr[24:20]};
                end else begin
                    fmt = FMT_I;
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = {{20{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = {{12{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21]};
            end
            OPC_LUI: begin
                fmt = FMT_U;
                imm = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                fmt = FMT_U;
                imm = {instr[31], instr[31:12], 11'b0};
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            default: begin
                fmt = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_decoder.sv
// RV32I decode stage with ID/EX register, load-use bubbles, hold and flush.
// Optional ID_ILLEGAL_TRAP_EN: undecodable instructions pass as valid bundles flagged o_illegal.
module id_stage_decoder
    import id_stage_decoder_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [31:0]           i_instr,
    input  logic [XLEN-1:0]       i_pc,
    input  logic                  i_hold,
    input  logic                  i_flush,
    output logic [REG_ADDR_W-1:0] o_rs1_addr,
    output logic [REG_ADDR_W-1:0] o_rs2_addr,
    input  logic [XLEN-1:0]       i_rs1_data,
    input  logic [XLEN-1:0]       i_rs2_data,
    output logic                  o_stall_if,
    output logic                  o_valid,
    output logic [XLEN-1:0]       o_A,
    output logic [XLEN-1:0]       o_B,
    output logic [XLEN-1:0]       o_Imm_SignExt,
    output logic [XLEN-1:0]       o_NPC,
    output logic [2:0]            o_ALUop,
    output logic [2:0]            o_func3,
    output logic                  o_func7,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_RegWrite,
    output logic                  o_MemToReg,
    output logic                  o_MemWrite,
    output logic                  o_illegal
);

    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    id_state_t       dec;
    id_state_t       state_q;
    logic            legal;
    logic            load_use;
    logic [2:0]      func3;

    id_stage_decoder_imm_gen u_imm_gen (
        .instr (i_instr),
        .imm   (imm),
        .fmt   (fmt)
    );

    assign func3      = i_instr[14:12];
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    // Decode the presented instruction into a candidate ID/EX bundle.
    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        dec.a      = i_rs1_data;
        dec.b      = i_rs2_data;
        dec.imm    = imm;
        dec.npc    = i_pc;
        dec.func3  = func3;
        dec.rd     = i_instr[11:7];
        dec.alu_op = ALU_LDST;
        case (i_instr[6:0])
            OPC_LOAD: begin
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                legal          = !(func3 inside {3'd3, 3'd6, 3'd7});
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.rd        = '0;
                legal         = (func3 <= 3'd2);
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_BRANCH;
                dec.rd     = '0;
                legal      = !(func3 inside {3'd2, 3'd3});
            end
            OPC_OP: begin
                dec.alu_op    = ALU_R;
                dec.func7     = i_instr[30];
                dec.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op    = ALU_I;
                dec.func7     = (fmt == FMT_SHAMT) ? i_instr[30] : 1'b0;
                dec.reg_write = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_LUI;
                dec.func3     = '0;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op    = ALU_AUIPC;
                dec.func3     = '0;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op    = ALU_JAL;
                dec.func3     = '0;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op    = ALU_JALR;
                dec.reg_write = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (dec.rd == '0) begin
            dec.reg_write = 1'b0;
        end

`ifdef ID_ILLEGAL_TRAP_EN
        if (!legal) begin
            dec.illegal    = 1'b1;
            dec.alu_op     = ALU_LDST;
            dec.rd         = '0;
            dec.reg_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.mem_write  = 1'b0;
        end
        dec.valid = i_valid;
`else
        dec.valid = i_valid && legal;
`endif
    end

    // Load in EX whose destination is read by the instruction now in ID.
    always_comb begin
        load_use = i_valid && state_q.valid && state_q.mem_to_reg && (state_q.rd != '0) &&
                   ((fmt_uses_rs1(fmt) && (o_rs1_addr == state_q.rd)) ||
                    (fmt_uses_rs2(fmt) && (o_rs2_addr == state_q.rd)));
    end

    assign o_stall_if = i_reset && !i_flush && (i_hold || load_use);

    // ID/EX register: flush > hold > load-use bubble > normal advance.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= '0;
        end else if (i_flush) begin
            state_q <= '0;
        end else if (i_hold) begin
            state_q <= state_q;
        end else if (load_use || !dec.valid) begin
            state_q <= '0;
        end else begin
            state_q <= dec;
        end
    end

    assign o_valid       = state_q.valid;
    assign o_A           = state_q.a;
    assign o_B           = state_q.b;
    assign o_Imm_SignExt = state_q.imm;
    assign o_NPC         = state_q.npc;
    assign o_ALUop       = state_q.alu_op;
    assign o_func3       = state_q.func3;
    assign o_func7       = state_q.func7;
    assign o_rd          = state_q.rd;
    assign o_RegWrite    = state_q.reg_write;
    assign o_MemToReg    = state_q.mem_to_reg;
    assign o_MemWrite    = state_q.mem_write;
    assign o_illegal     = state_q.illegal;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Self-checking bench for id_stage_decoder: directed cases followed by randomized
// instruction streams compared against an instruction-level reference model.
module tb_id_stage_decoder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_hold;
    logic        i_flush;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_stall_if;
    logic        o_valid;
    logic [31:0] o_A;
    logic [31:0] o_B;
    logic [31:0] o_Imm_SignExt;
    logic [31:0] o_NPC;
    logic [2:0]  o_ALUop;
    logic [2:0]  o_func3;
    logic        o_func7;
    logic [4:0]  o_rd;
    logic        o_RegWrite;
    logic        o_MemToReg;
    logic        o_MemWrite;
    logic        o_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [2:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
        logic        mw;
    } bundle_t;

    bundle_t m;

    id_stage_decoder dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_instr       (i_instr),
        .i_pc          (i_pc),
        .i_hold        (i_hold),
        .i_flush       (i_flush),
        .o_rs1_addr    (o_rs1_addr),
        .o_rs2_addr    (o_rs2_addr),
        .i_rs1_data    (i_rs1_data),
        .i_rs2_data    (i_rs2_data),
        .o_stall_if    (o_stall_if),
        .o_valid       (o_valid),
        .o_A           (o_A),
        .o_B           (o_B),
        .o_Imm_SignExt (o_Imm_SignExt),
        .o_NPC         (o_NPC),
        .o_ALUop       (o_ALUop),
        .o_func3       (o_func3),
        .o_func7       (o_func7),
        .o_rd          (o_rd),
        .o_RegWrite    (o_RegWrite),
        .o_MemToReg    (o_MemToReg),
        .o_MemWrite    (o_MemWrite),
        .o_illegal     (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: field meanings computed arithmetically from the ISA encoding.
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic v);
        bundle_t    r;
        logic       legal;
        logic [2:0] f3;
        int         off;
        int         up;
        r     = '0;
        legal = 1'b1;
        f3    = ins[14:12];
        r.a   = a;
        r.b   = b;
        r.npc = pc;
        r.f3  = f3;
        r.rd  = ins[11:7];
        case (ins[6:0])
            7'h03: begin
                r.mtr = 1'b1; r.rw = 1'b1;
                r.imm = 32'(int'($signed(ins[31:20])));
                legal = !(f3 == 3'd3 || f3 >= 3'd6);
            end
            7'h23: begin
                r.mw  = 1'b1; r.rd = 5'd0;
                r.imm = 32'(int'($signed({ins[31:25], ins[11:7]})));
                legal = (f3 <= 3'd2);
            end
            7'h63: begin
                r.aluop = 3'd1; r.rd = 5'd0;
                off     = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                r.imm   = 32'(off / 2);
                legal   = (f3 != 3'd2 && f3 != 3'd3);
            end
            7'h33: begin
                r.aluop = 3'd2; r.rw = 1'b1; r.f7 = ins[30];
            end
            7'h13: begin
                r.aluop = 3'd3; r.rw = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    r.imm = 32'(ins[24:20]);
                    r.f7  = ins[30];
                end else begin
                    r.imm = 32'(int'($signed(ins[31:20])));
                end
            end
            7'h37: begin
                r.aluop = 3'd4; r.rw = 1'b1; r.f3 = 3'd0;
                r.imm   = 32'(ins[31:12]) * 32'd4096;
            end
            7'h17: begin
                r.aluop = 3'd5; r.rw = 1'b1; r.f3 = 3'd0;
                up      = int'(32'(ins[31:12]) * 32'd4096);
                r.imm   = 32'(up / 2);
            end
            7'h6F: begin
                r.aluop = 3'd6; r.rw = 1'b1; r.f3 = 3'd0;
                off     = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                r.imm   = 32'(off / 2);
            end
            7'h67: begin
                r.aluop = 3'd7; r.rw = 1'b1;
                r.imm   = 32'(int'($signed(ins[31:20])));
            end
            default: legal = 1'b0;
        endcase
        if (r.rd == 5'd0) r.rw = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        if (!legal) begin
            r.illegal = 1'b1; r.aluop = 3'd0; r.rd = 5'd0;
            r.rw = 1'b0; r.mtr = 1'b0; r.mw = 1'b0;
        end
        r.valid = v;
`else
        r.valid = v && legal;
`endif
        if (!r.valid) r = '0;
        return r;
    endfunction

    function automatic logic ref_load_use();
        logic [6:0] opc;
        logic       use1;
        logic       use2;
        opc  = i_instr[6:0];
        use1 = (opc == 7'h03 || opc == 7'h23 || opc == 7'h63 || opc == 7'h33 ||
                opc == 7'h13 || opc == 7'h67);
        use2 = (opc == 7'h23 || opc == 7'h63 || opc == 7'h33);
        return i_valid && m.valid && m.mtr && (m.rd != 5'd0) &&
               ((use1 && i_instr[19:15] == m.rd) || (use2 && i_instr[24:20] == m.rd));
    endfunction

    task automatic check_regs();
        check_eq("valid", 32'(o_valid), 32'(m.valid));
        check_eq("illegal", 32'(o_illegal), 32'(m.illegal));
        check_eq("regwrite", 32'(o_RegWrite), 32'(m.rw));
        check_eq("memtoreg", 32'(o_MemToReg), 32'(m.mtr));
        check_eq("memwrite", 32'(o_MemWrite), 32'(m.mw));
        if (m.valid) begin
            check_eq("aluop", 32'(o_ALUop), 32'(m.aluop));
            check_eq("func3", 32'(o_func3), 32'(m.f3));
            check_eq("func7", 32'(o_func7), 32'(m.f7));
            check_eq("rd", 32'(o_rd), 32'(m.rd));
            if (!m.illegal) begin
                check_eq("A", o_A, m.a);
                check_eq("B", o_B, m.b);
                check_eq("npc", o_NPC, m.npc);
                if (m.aluop != 3'd2) check_eq("imm", o_Imm_SignExt, m.imm);
            end
        end
    endtask

    task automatic check_zero();
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_A", o_A, 32'd0);
        check_eq("rst_B", o_B, 32'd0);
        check_eq("rst_imm", o_Imm_SignExt, 32'd0);
        check_eq("rst_npc", o_NPC, 32'd0);
        check_eq("rst_ctrl", {19'd0, o_ALUop, o_func3, o_func7, o_rd}, 32'd0);
        check_eq("rst_en", {28'd0, o_RegWrite, o_MemToReg, o_MemWrite, o_illegal}, 32'd0);
        check_eq("rst_stall", 32'(o_stall_if), 32'd0);
    endtask

    // One clock: check combinational outputs, take the edge, update model, check registers.
    task automatic cycle();
        logic exp_stall;
        #1;
        exp_stall = !i_flush && (i_hold || ref_load_use());
        check_eq("stall_if", 32'(o_stall_if), 32'(exp_stall));
        check_eq("rs1_addr", 32'(o_rs1_addr), 32'(i_instr[19:15]));
        check_eq("rs2_addr", 32'(o_rs2_addr), 32'(i_instr[24:20]));
        @(posedge i_clk);
        if (i_flush) m = '0;
        else if (i_hold) m = m;
        else if (ref_load_use()) m = '0;
        else m = ref_decode(i_instr, i_pc, i_rs1_data, i_rs2_data, i_valid);
        #1;
        check_regs();
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic v, input logic h, input logic f);
        i_instr = ins; i_pc = pc; i_rs1_data = a; i_rs2_data = b;
        i_valid = v; i_hold = h; i_flush = f;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 10))
            0:       w[6:0] = 7'h03;
            1:       w[6:0] = 7'h23;
            2:       w[6:0] = 7'h63;
            3, 4:    w[6:0] = 7'h33;
            5:       w[6:0] = 7'h13;
            6:       w[6:0] = 7'h37;
            7:       w[6:0] = 7'h17;
            8:       w[6:0] = 7'h6F;
            9:       w[6:0] = 7'h67;
            default: w[6:0] = 7'($urandom());
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        m = '0;
        drive(32'h0000_0013, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        #1;
        check_zero();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;

        // ADD x3,x1,x2
        drive(32'h0020_81B3, 32'h0000_0040, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        cycle();
        check_eq("t1_aluop", 32'(o_ALUop), 32'd2);
        check_eq("t1_f7", 32'(o_func7), 32'd0);
        check_eq("t1_A", o_A, 32'd5);
        check_eq("t1_B", o_B, 32'd7);
        check_eq("t1_rd", 32'(o_rd), 32'd3);
        check_eq("t1_rw", 32'(o_RegWrite), 32'd1);

        // ADDI x1,x0,-1
        drive(32'hFFF0_0093, 32'h0000_0044, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        check_eq("t2_aluop", 32'(o_ALUop), 32'd3);
        check_eq("t2_imm", o_Imm_SignExt, 32'hFFFF_FFFF);
        check_eq("t2_f7", 32'(o_func7), 32'd0);

        // BEQ x1,x2,+8
        drive(32'h0020_8463, 32'h0000_0100, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
        cycle();
        check_eq("t3_aluop", 32'(o_ALUop), 32'd1);
        check_eq("t3_imm", o_Imm_SignExt, 32'd4);
        check_eq("t3_npc", o_NPC, 32'h0000_0100);
        check_eq("t3_rw", 32'(o_RegWrite), 32'd0);
        check_eq("t3_rd", 32'(o_rd), 32'd0);

        // LW x5,0(x1) then dependent ADD x6,x5,x5: one stall, one bubble
        drive(32'h0000_A283, 32'h0000_0104, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(32'h0052_8333, 32'h0000_0108, 32'd11, 32'd11, 1'b1, 1'b0, 1'b0);
        #1 check_eq("t4_stall", 32'(o_stall_if), 32'd1);
        cycle();
        check_eq("t4_bubble", 32'(o_valid), 32'd0);
        #1 check_eq("t4_nostall", 32'(o_stall_if), 32'd0);
        cycle();
        check_eq("t4_valid", 32'(o_valid), 32'd1);
        check_eq("t4_rd", 32'(o_rd), 32'd6);

        // Load-use hazard coinciding with flush
        drive(32'h0000_A283, 32'h0000_0200, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(32'h0052_8333, 32'h0000_0204, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1);
        #1 check_eq("t5_stall", 32'(o_stall_if), 32'd0);
        cycle();
        check_eq("t5_valid", 32'(o_valid), 32'd0);
        drive(32'h0052_8333, 32'h0000_0300, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
        #1 check_eq("t5_nostall", 32'(o_stall_if), 32'd0);
        cycle();
        check_eq("t5_emit", 32'(o_valid), 32'd1);
        check_eq("t5_rd", 32'(o_rd), 32'd6);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                // asynchronous reset while downstream is holding
                i_hold = 1'b1;
                #2 i_reset = 1'b0;
                #1 check_zero();
                m = '0;
                @(posedge i_clk);
                #1 check_zero();
                i_reset = 1'b1;
            end
            drive(rand_instr(), $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom(),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 11) == 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
